seq_matrix_multiplier: RTL and testbench

SEQ_MATRIX_MULTIPLIER -- requirements
Module: seq_matrix_multiplier

---
 rtl/seq_mm_pkg.sv | 32 +++
 rtl/mac_unit.sv | 103 ++++++++++
 rtl/seq_matrix_multiplier.sv | 154 +++++++++++++++
 tb/tb_seq_matrix_multiplier.sv | 344 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/seq_mm_pkg.sv
// -----------------------------------------------------------------------------
// seq_mm_pkg
// Shared definitions for the sequential matrix multiplier:
//   - FSM state encoding (plain constants plus an enum built on them)
//   - accumulator width helper
//   - index-counter width helper
// -----------------------------------------------------------------------------
package seq_mm_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_MAC  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    typedef enum logic [1:0] {
        S_IDLE = ST_IDLE,
        S_MAC  = ST_MAC,
        S_DONE = ST_DONE
    } state_t;

    // Full-precision product is 2*DW bits.  Summing K_INNER of them needs
    // $clog2(K_INNER) growth bits.  One further bit keeps the unsigned case
    // positive when the accumulator is handled as a signed quantity.
    function automatic int acc_width(input int dw, input int k_inner);
        return 2 * dw + $clog2(k_inner) + 1;
    endfunction

    // Index counters need at least one bit, even for a dimension of 1.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/mac_unit.sv
// -----------------------------------------------------------------------------
// mac_unit
// Multiply-accumulate with a wrap / saturate reducer on the running sum.
//
// Ports
//   clk       : clock, rising edge
//   rst       : synchronous active-high reset, clears the accumulator
//   clr       : clear the accumulator (start of a new operation)
//   en        : perform one multiply-accumulate this cycle
//   last      : this product is the last term of the current element;
//               the accumulator is cleared instead of updated
//   sat_mode  : 1 = clamp the reduced result, 0 = keep the low CW bits
//   a, b      : operand elements (two's complement when SIGNED = 1)
//   red       : reduced value of (acc + a*b), valid while en is high
// -----------------------------------------------------------------------------
module mac_unit #(
    parameter int DW     = 8,
    parameter int ACC_W  = 18,
    parameter int CW     = 17,
    parameter int SIGNED = 0
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr,
    input  logic          en,
    input  logic          last,
    input  logic          sat_mode,
    input  logic [DW-1:0] a,
    input  logic [DW-1:0] b,
    output logic [CW-1:0] red
);

    localparam int PW = 2 * DW + 2;

    logic signed [DW:0]      a_ext;
    logic signed [DW:0]      b_ext;
    logic signed [PW-1:0]    prod;
    logic signed [ACC_W-1:0] prod_ext;
    logic signed [ACC_W-1:0] acc_q;
    logic signed [ACC_W-1:0] sum;

    // Operands are widened by one bit so that a single signed multiplier
    // serves both modes: unsigned data gets a zero MSB, signed data a copy
    // of its sign bit.
    always_comb begin
        if (SIGNED != 0) begin
            a_ext = signed'({a[DW-1], a});
            b_ext = signed'({b[DW-1], b});
        end else begin
            a_ext = signed'({1'b0, a});
            b_ext = signed'({1'b0, b});
        end
        prod     = PW'(a_ext) * PW'(b_ext);
        // The product magnitude always fits in 2*DW+1 signed bits, so a
        // narrowing resize (K_INNER = 1) loses nothing.
        prod_ext = ACC_W'(prod);
        sum      = acc_q + prod_ext;
    end

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            acc_q <= '0;
        end else if (en) begin
            acc_q <= last ? '0 : sum;
        end
    end

    generate
        if (CW < ACC_W) begin : g_narrow
            localparam logic [CW-1:0] U_MAX = '1;
            localparam logic [CW-1:0] S_MAX = U_MAX >> 1;
            localparam logic [CW-1:0] S_MIN = ~S_MAX;

            // Value fits when every bit above the result field repeats the
            // result sign (signed) or is zero (unsigned).
            function automatic logic [CW-1:0] reduce(
                input logic signed [ACC_W-1:0] v,
                input logic                    sat
            );
                logic fits;
                if (SIGNED != 0) begin
                    fits = (&v[ACC_W-1:CW-1]) | ~(|v[ACC_W-1:CW-1]);
                end else begin
                    fits = ~(|v[ACC_W-1:CW]);
                end
                if (!sat || fits) begin
                    return v[CW-1:0];
                end else if (SIGNED != 0) begin
                    return v[ACC_W-1] ? S_MIN : S_MAX;
                end else begin
                    return U_MAX;
                end
            endfunction

            always_comb red = reduce(sum, sat_mode);
        end else begin : g_wide
            // Result field is at least as wide as the accumulator: nothing
            // can overflow, so both modes reduce to a plain extension.
            always_comb red = CW'(sum);
        end
    endgenerate

endmodule

// File: rtl/seq_matrix_multiplier.sv
// -----------------------------------------------------------------------------
// seq_matrix_multiplier
// Computes C = A x B one product per clock through a single MAC unit.
// A is M_ROWS x K_INNER, B is K_INNER x N_COLS, C is M_ROWS x N_COLS.
//
// Ports
//   clk       : clock, rising edge
//   rst       : synchronous active-high reset (wins over start)
//   start     : request a multiply; accepted only while idle
//   sat_mode  : 1 = saturate results to CW bits, 0 = wrap
//   A         : element (r,k) at bit offset (r*K_INNER+k)*DW
//   B         : element (k,c) at bit offset (k*N_COLS+c)*DW
//   busy      : high while an operation is running (MAC and DONE)
//   done      : one-cycle completion pulse
//   C         : element (r,c) at bit offset (r*N_COLS+c)*CW
// -----------------------------------------------------------------------------
module seq_matrix_multiplier
    import seq_mm_pkg::*;
#(
    parameter int M_ROWS  = 3,
    parameter int K_INNER = 2,
    parameter int N_COLS  = 6,
    parameter int DW      = 8,
    parameter int CW      = 2 * DW + $clog2(K_INNER),
    parameter int SIGNED  = 0
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             start,
    input  logic                             sat_mode,
    input  logic [M_ROWS*K_INNER*DW-1:0]     A,
    input  logic [K_INNER*N_COLS*DW-1:0]     B,
    output logic                             busy,
    output logic                             done,
    output logic [M_ROWS*N_COLS*CW-1:0]      C
);

    localparam int ACC_W = acc_width(DW, K_INNER);
    localparam int RW    = idx_width(M_ROWS);
    localparam int KW    = idx_width(K_INNER);
    localparam int NW    = idx_width(N_COLS);

    localparam logic [RW-1:0] R_LAST = RW'(M_ROWS - 1);
    localparam logic [KW-1:0] K_LAST = KW'(K_INNER - 1);
    localparam logic [NW-1:0] C_LAST = NW'(N_COLS - 1);

    state_t                          state;
    logic [RW-1:0]                   r_idx;
    logic [KW-1:0]                   k_idx;
    logic [NW-1:0]                   c_idx;

    logic [M_ROWS*K_INNER*DW-1:0]    a_q;
    logic [K_INNER*N_COLS*DW-1:0]    b_q;
    logic                            sat_q;
    logic [M_ROWS*N_COLS*CW-1:0]     c_q;

    logic                            accept;
    logic                            mac_en;
    logic                            k_last;
    logic [DW-1:0]                   a_elem;
    logic [DW-1:0]                   b_elem;
    logic [CW-1:0]                   red;
    int                              c_off;

    always_comb begin
        accept = (state == S_IDLE) && start;
        mac_en = (state == S_MAC);
        k_last = (k_idx == K_LAST);
        a_elem = a_q[(int'(r_idx) * K_INNER + int'(k_idx)) * DW +: DW];
        b_elem = b_q[(int'(k_idx) * N_COLS + int'(c_idx)) * DW +: DW];
        c_off  = (int'(r_idx) * N_COLS + int'(c_idx)) * CW;
    end

    // Operand snapshot: later changes on A/B/sat_mode cannot disturb a
    // running operation.  Pure data, so no reset.
    always_ff @(posedge clk) begin
        if (accept) begin
            a_q   <= A;
            b_q   <= B;
            sat_q <= sat_mode;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
            r_idx <= '0;
            c_idx <= '0;
            k_idx <= '0;
            c_q   <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        r_idx <= '0;
                        c_idx <= '0;
                        k_idx <= '0;
                        state <= S_MAC;
                    end
                end
                S_MAC: begin
                    if (k_last) begin
                        // Last term of element (r,c): the reducer already sees
                        // acc + this product, so commit it and move on.  Other
                        // elements of C keep their previous contents.
                        c_q[c_off +: CW] <= red;
                        k_idx <= '0;
                        if (c_idx == C_LAST) begin
                            c_idx <= '0;
                            if (r_idx == R_LAST) begin
                                r_idx <= '0;
                                state <= S_DONE;
                            end else begin
                                r_idx <= r_idx + RW'(1);
                            end
                        end else begin
                            c_idx <= c_idx + NW'(1);
                        end
                    end else begin
                        k_idx <= k_idx + KW'(1);
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    mac_unit #(
        .DW     (DW),
        .ACC_W  (ACC_W),
        .CW     (CW),
        .SIGNED (SIGNED)
    ) u_mac (
        .clk      (clk),
        .rst      (rst),
        .clr      (accept),
        .en       (mac_en),
        .last     (k_last),
        .sat_mode (sat_q),
        .a        (a_elem),
        .b        (b_elem),
        .red      (red)
    );

    assign busy = (state != S_IDLE);
    assign done = (state == S_DONE);
    assign C    = c_q;

endmodule

// File: tb/tb_seq_matrix_multiplier.sv
// -----------------------------------------------------------------------------
// tb_seq_matrix_multiplier
// Three 3x2x6 instances share start/rst timing but get their own operands:
//   dut 0: defaults (unsigned, CW=17)
//   dut 1: unsigned, CW=8
//   dut 2: signed,   CW=8
// A reference model (plain integer matrix arithmetic plus the element write
// schedule) predicts busy/done/C of all three every cycle.  A fourth 1x1x1
// instance is exercised with directed literal checks.
// -----------------------------------------------------------------------------
module tb_seq_matrix_multiplier;

    localparam int P  = 36;
    localparam int K  = 2;
    localparam int NE = 18;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst;
    logic         start;
    logic [2:0]   sat_in;
    logic [2:0]   busy;
    logic [2:0]   done;
    logic [47:0]  a_in [3];
    logic [95:0]  b_in [3];
    logic [305:0] c0;
    logic [143:0] c1;
    logic [143:0] c2;

    logic         start3;
    logic         sat3;
    logic [7:0]   a3;
    logic [7:0]   b3;
    logic         busy3;
    logic         done3;
    logic [15:0]  c3;

    int n_total = 0;
    int n_bad   = 0;
    bit chk_en  = 1'b0;

    int m_n = 0;
    int res   [3][NE];
    int exp_c [3][NE];

    seq_matrix_multiplier #(.SIGNED(0)) u_dut0 (
        .clk(clk), .rst(rst), .start(start), .sat_mode(sat_in[0]),
        .A(a_in[0]), .B(b_in[0]), .busy(busy[0]), .done(done[0]), .C(c0)
    );
    seq_matrix_multiplier #(.CW(8), .SIGNED(0)) u_dut1 (
        .clk(clk), .rst(rst), .start(start), .sat_mode(sat_in[1]),
        .A(a_in[1]), .B(b_in[1]), .busy(busy[1]), .done(done[1]), .C(c1)
    );
    seq_matrix_multiplier #(.CW(8), .SIGNED(1)) u_dut2 (
        .clk(clk), .rst(rst), .start(start), .sat_mode(sat_in[2]),
        .A(a_in[2]), .B(b_in[2]), .busy(busy[2]), .done(done[2]), .C(c2)
    );
    seq_matrix_multiplier #(.M_ROWS(1), .K_INNER(1), .N_COLS(1)) u_dut3 (
        .clk(clk), .rst(rst), .start(start3), .sat_mode(sat3),
        .A(a3), .B(b3), .busy(busy3), .done(done3), .C(c3)
    );

    task automatic check(input string name, input logic [319:0] got, input logic [319:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    function automatic int cw_of(input int d);
        return (d == 0) ? 17 : 8;
    endfunction

    function automatic bit sgn_of(input int d);
        return d == 2;
    endfunction

    // One element of C for a 3x2x6 product, from plain integer arithmetic.
    function automatic int ref_elem(input logic [47:0] a, input logic [95:0] b,
                                    input int r, input int c, input bit sgn,
                                    input int cw, input bit sat);
        longint s;
        longint x;
        longint y;
        longint hi;
        longint lo;
        logic [7:0] ab;
        logic [7:0] bb;
        s = 0;
        for (int k = 0; k < 2; k++) begin
            ab = a[(r * 2 + k) * 8 +: 8];
            bb = b[(k * 6 + c) * 8 +: 8];
            x = longint'(ab);
            y = longint'(bb);
            if (sgn) begin
                if (x > 127) x -= 256;
                if (y > 127) y -= 256;
            end
            s += x * y;
        end
        if (sgn) begin
            hi = (64'sd1 <<< (cw - 1)) - 1;
            lo = -(64'sd1 <<< (cw - 1));
        end else begin
            hi = (64'sd1 <<< cw) - 1;
            lo = 0;
        end
        if (sat) begin
            if (s > hi) s = hi;
            if (s < lo) s = lo;
        end
        return int'(s & ((64'sd1 <<< cw) - 1));
    endfunction

    function automatic logic [319:0] exp_vec(input int d);
        logic [319:0] v;
        int cw;
        v  = '0;
        cw = cw_of(d);
        for (int e = 0; e < NE; e++)
            for (int bi = 0; bi < cw; bi++)
                v[e * cw + bi] = exp_c[d][e][bi];
        return v;
    endfunction

    function automatic logic [319:0] got_vec(input int d);
        if (d == 0) return 320'(c0);
        if (d == 1) return 320'(c1);
        return 320'(c2);
    endfunction

    // Reference model.  m_n = 0 when idle, else the cycle number since the
    // accepting edge (1..P+1).  Element j is written at the edge that ends
    // cycle (j+1)*K; done is high in cycle P+1.
    always @(posedge clk) begin
        if (rst) begin
            m_n = 0;
            for (int d = 0; d < 3; d++)
                for (int e = 0; e < NE; e++)
                    exp_c[d][e] = 0;
        end else if (m_n == 0) begin
            if (start) begin
                for (int d = 0; d < 3; d++)
                    for (int e = 0; e < NE; e++)
                        res[d][e] = ref_elem(a_in[d], b_in[d], e / 6, e % 6,
                                             sgn_of(d), cw_of(d), sat_in[d]);
                m_n = 1;
            end
        end else begin
            if (m_n <= P && (m_n % K) == 0)
                for (int d = 0; d < 3; d++)
                    exp_c[d][m_n / K - 1] = res[d][m_n / K - 1];
            m_n = (m_n == P + 1) ? 0 : m_n + 1;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            for (int d = 0; d < 3; d++) begin
                check($sformatf("busy%0d", d), 320'(busy[d]), 320'(m_n != 0));
                check($sformatf("done%0d", d), 320'(done[d]), 320'(m_n == P + 1));
                check($sformatf("C%0d", d), got_vec(d), exp_vec(d));
            end
        end
    end

    task automatic randomize_inputs();
        for (int d = 0; d < 3; d++) begin
            a_in[d] = {16'($urandom()), $urandom()};
            b_in[d] = {$urandom(), $urandom(), $urandom()};
        end
        sat_in = 3'($urandom());
    endtask

    // Pulse start, optionally scramble inputs while running; returns the
    // cycle in which done rose (-1 on timeout) and the number of busy cycles.
    task automatic run_op(input bit toggle, output int dcyc, output int nbusy);
        dcyc  = -1;
        nbusy = 0;
        start = 1'b1;
        for (int cyc = 1; cyc <= 60; cyc++) begin
            @(negedge clk);
            if (cyc == 1) start = 1'b0;
            if (toggle) randomize_inputs();
            if (busy[0]) nbusy++;
            if (done[0]) begin
                dcyc = cyc;
                break;
            end
        end
    endtask

    task automatic wait_idle();
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 100; i++) begin
            if (!busy[0]) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        check("idle_timeout", 320'(ok), 320'(1));
    endtask

    initial begin
        int dcyc;
        int nbusy;
        int dt [$];
        bit seen_done;

        rst    = 1'b1;
        start  = 1'b0;
        start3 = 1'b0;
        sat3   = 1'b0;
        a3     = '0;
        b3     = '0;
        sat_in = '0;
        for (int d = 0; d < 3; d++) begin
            a_in[d] = '0;
            b_in[d] = '0;
        end
        repeat (2) @(negedge clk);
        chk_en = 1'b1;
        check("rst_busy", 320'(busy), 320'(0));
        check("rst_c0", 320'(c0), 320'(0));
        check("rst_busy3", 320'(busy3), 320'(0));
        rst = 1'b0;

        // Hand-computed values that pin the reference model.
        check("model_ones_twos", 320'(ref_elem({6{8'd1}}, {12{8'd2}}, 0, 0, 1'b0, 17, 1'b0)), 320'(4));
        check("model_ff_wrap", 320'(ref_elem({6{8'hFF}}, {12{8'hFF}}, 2, 5, 1'b0, 8, 1'b0)), 320'(2));
        check("model_ff_sat", 320'(ref_elem({6{8'hFF}}, {12{8'hFF}}, 1, 3, 1'b0, 8, 1'b1)), 320'(255));
        check("model_s128_sat", 320'(ref_elem({6{8'h80}}, {12{8'h80}}, 0, 4, 1'b1, 8, 1'b1)), 320'(127));
        check("model_neg6", 320'(ref_elem({6{8'hFF}}, {12{8'h03}}, 2, 0, 1'b1, 8, 1'b1)), 320'(250));

        // All-ones x all-twos, 0xFF saturation, -128 saturation.
        a_in[0] = {6{8'd1}};   b_in[0] = {12{8'd2}};   sat_in[0] = 1'b0;
        a_in[1] = {6{8'hFF}};  b_in[1] = {12{8'hFF}};  sat_in[1] = 1'b1;
        a_in[2] = {6{8'h80}};  b_in[2] = {12{8'h80}};  sat_in[2] = 1'b1;
        run_op(1'b0, dcyc, nbusy);
        check("done_cycle", 320'(dcyc), 320'(37));
        check("busy_cycles", 320'(nbusy), 320'(37));
        check("c0_all4", 320'(c0), 320'({18{17'd4}}));
        check("c1_sat_ff", 320'(c1), 320'({18{8'hFF}}));
        check("c2_sat_127", 320'(c2), 320'({18{8'd127}}));
        @(negedge clk);
        check("busy_after_done", 320'(busy[0]), 320'(0));

        // Wrap mode and negative result, with inputs scrambled mid-operation.
        randomize_inputs();
        a_in[1] = {6{8'hFF}};  b_in[1] = {12{8'hFF}};  sat_in[1] = 1'b0;
        a_in[2] = {6{8'hFF}};  b_in[2] = {12{8'h03}};  sat_in[2] = 1'b1;
        run_op(1'b1, dcyc, nbusy);
        check("done_cycle_toggle", 320'(dcyc), 320'(37));
        check("c1_wrap_02", 320'(c1), 320'({18{8'h02}}));
        check("c2_neg6", 320'(c2), 320'({18{8'hFA}}));
        wait_idle();

        // Start held high: one done every 38 cycles.
        start = 1'b1;
        for (int cyc = 1; cyc <= 120; cyc++) begin
            @(negedge clk);
            randomize_inputs();
            if (done[0]) dt.push_back(cyc);
        end
        start = 1'b0;
        check("held_done_count", 320'(dt.size()), 320'(3));
        if (dt.size() >= 3) begin
            check("held_first", 320'(dt[0]), 320'(37));
            check("held_period1", 320'(dt[1] - dt[0]), 320'(38));
            check("held_period2", 320'(dt[2] - dt[1]), 320'(38));
        end
        wait_idle();

        // Reset in cycle 10 of an operation.
        randomize_inputs();
        seen_done = 1'b0;
        start = 1'b1;
        for (int cyc = 1; cyc <= 10; cyc++) begin
            @(negedge clk);
            start = 1'b0;
            if (done[0]) seen_done = 1'b1;
        end
        rst = 1'b1;
        @(negedge clk);
        if (done[0]) seen_done = 1'b1;
        check("abort_busy", 320'(busy), 320'(0));
        check("abort_c0", 320'(c0), 320'(0));
        check("abort_c2", 320'(c2), 320'(0));
        check("abort_no_done", 320'(seen_done), 320'(0));
        rst = 1'b0;
        randomize_inputs();
        run_op(1'b0, dcyc, nbusy);
        check("after_abort_done", 320'(dcyc), 320'(37));
        wait_idle();

        // Rst and start together: rst wins.
        rst   = 1'b1;
        start = 1'b1;
        @(negedge clk);
        check("rst_over_start", 320'(busy), 320'(0));
        rst   = 1'b0;
        start = 1'b0;

        // Random traffic: start, occasional reset, input churn.
        for (int cyc = 0; cyc < 1500; cyc++) begin
            @(negedge clk);
            start = ($urandom_range(3) == 0);
            rst   = ($urandom_range(199) == 0);
            if ($urandom_range(2) == 0) randomize_inputs();
        end
        start = 1'b0;
        rst   = 1'b0;
        wait_idle();

        // 1x1x1 instance: 5*7 = 35, done two cycles after start.
        a3 = 8'd5;
        b3 = 8'd7;
        start3 = 1'b1;
        @(negedge clk);
        start3 = 1'b0;
        check("u3_busy_c1", 320'(busy3), 320'(1));
        check("u3_done_c1", 320'(done3), 320'(0));
        @(negedge clk);
        check("u3_done_c2", 320'(done3), 320'(1));
        check("u3_c", 320'(c3), 320'(35));
        @(negedge clk);
        check("u3_busy_c3", 320'(busy3), 320'(0));
        check("u3_c_hold", 320'(c3), 320'(35));

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1);
    end

endmodule
